// File: rtl/ldpc_r2c_scheduler.sv
// Sequencing controller for the LDPC row/column exchange datapath: row phase, pipeline
// drain, column phase and parity check per iteration, until convergence or the iteration limit.
module ldpc_r2c_scheduler #(
    parameter int NUM_ROWS = 7,
    parameter int NUM_COLS = 6,
    parameter int PIPE_LAT = 2,
    parameter int ITER_W   = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [ITER_W-1:0]           i_max_iter,
    input  logic                        i_ready,
    input  logic                        i_parity_valid,
    input  logic                        i_parity_ok,
    input  logic                        i_abort,
    output logic                        o_row_valid,
    output logic [$clog2(NUM_ROWS)-1:0] o_row_idx,
    output logic                        o_col_valid,
    output logic [$clog2(NUM_COLS)-1:0] o_col_idx,
    output logic [ITER_W-1:0]           o_iter,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_converged
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [ROW_W-1:0]  ROW_ZERO = ROW_W'(0);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_ZERO = COL_W'(0);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [DRN_W-1:0]  DRN_ZERO = DRN_W'(0);
    localparam logic [DRN_W-1:0]  DRN_ONE  = DRN_W'(1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(PIPE_LAT - 1);
    localparam logic [ITER_W-1:0] ITER_ZERO = ITER_W'(0);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROW   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_COL   = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [ROW_W-1:0]  row_r, row_s;
    logic [COL_W-1:0]  col_r, col_s;
    logic [DRN_W-1:0]  drain_r, drain_s;
    logic [ITER_W-1:0] iter_r, iter_s;
    logic [ITER_W-1:0] limit_r, limit_s;
    logic              converged_r, converged_s;
    logic              row_valid_r;
    logic              col_valid_r;
    logic              busy_r;
    logic              done_r;

    // Next-state, counter and result decode; abort overrides every other transition
    always_comb begin
        state_s     = state_r;
        row_s       = row_r;
        col_s       = col_r;
        drain_s     = drain_r;
        iter_s      = iter_r;
        limit_s     = limit_r;
        converged_s = converged_r;
        if ((state_r != ST_IDLE) && i_abort) begin
            state_s     = ST_IDLE;
            row_s       = ROW_ZERO;
            col_s       = COL_ZERO;
            drain_s     = DRN_ZERO;
            converged_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        // A zero limit still runs one full iteration
                        limit_s     = (i_max_iter == ITER_ZERO) ? ITER_ONE : i_max_iter;
                        iter_s      = ITER_ZERO;
                        row_s       = ROW_ZERO;
                        converged_s = 1'b0;
                        state_s     = ST_ROW;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ROW: begin
                    if (i_ready) begin
                        if (row_r == ROW_LAST) begin
                            row_s   = ROW_ZERO;
                            drain_s = DRN_ZERO;
                            state_s = ST_DRAIN;
                        end else begin
                            row_s = row_r + ROW_ONE;
                        end
                    end else begin
                        row_s = row_r;
                    end
                end
                ST_DRAIN: begin
                    if (drain_r == DRN_LAST) begin
                        drain_s = DRN_ZERO;
                        col_s   = COL_ZERO;
                        state_s = ST_COL;
                    end else begin
                        drain_s = drain_r + DRN_ONE;
                    end
                end
                ST_COL: begin
                    if (i_ready) begin
                        if (col_r == COL_LAST) begin
                            col_s   = COL_ZERO;
                            state_s = ST_CHECK;
                        end else begin
                            col_s = col_r + COL_ONE;
                        end
                    end else begin
                        col_s = col_r;
                    end
                end
                ST_CHECK: begin
                    if (i_parity_valid) begin
                        if (i_parity_ok) begin
                            converged_s = 1'b1;
                            state_s     = ST_DONE;
                        end else if (iter_r == (limit_r - ITER_ONE)) begin
                            converged_s = 1'b0;
                            state_s     = ST_DONE;
                        end else begin
                            iter_s  = iter_r + ITER_ONE;
                            row_s   = ROW_ZERO;
                            state_s = ST_ROW;
                        end
                    end else begin
                        state_s = ST_CHECK;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            row_r       <= ROW_ZERO;
            col_r       <= COL_ZERO;
            drain_r     <= DRN_ZERO;
            iter_r      <= ITER_ZERO;
            limit_r     <= ITER_ZERO;
            converged_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            row_r       <= row_s;
            col_r       <= col_s;
            drain_r     <= drain_s;
            iter_r      <= iter_s;
            limit_r     <= limit_s;
            converged_r <= converged_s;
        end
    end

    // Status flags registered from the next state so they line up with the counters
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            row_valid_r <= 1'b0;
            col_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            row_valid_r <= (state_s == ST_ROW);
            col_valid_r <= (state_s == ST_COL);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign o_row_valid = row_valid_r;
    assign o_row_idx   = row_r;
    assign o_col_valid = col_valid_r;
    assign o_col_idx   = col_r;
    assign o_iter      = iter_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_converged = converged_r;

endmodule

// File: tb/tb_ldpc_r2c_scheduler.sv
// Self-checking bench for ldpc_r2c_scheduler: directed timeline scenarios plus randomized
// decodes compared against a beat/iteration-level reference model.
module tb_ldpc_r2c_scheduler;

    localparam int NR = 7;
    localparam int NC = 6;
    localparam int PL = 2;
    localparam int BUDGET = 2000;

    logic       clk;
    logic       i_reset;
    logic       i_start;
    logic [3:0] i_max_iter;
    logic       i_ready;
    logic       i_parity_valid;
    logic       i_parity_ok;
    logic       i_abort;
    logic       o_row_valid;
    logic [2:0] o_row_idx;
    logic       o_col_valid;
    logic [2:0] o_col_idx;
    logic [3:0] o_iter;
    logic       o_busy;
    logic       o_done;
    logic       o_converged;

    int pass_cnt = 0;
    int total_cnt = 0;

    int done_cyc, done_count, done_conv, done_iter, overlap, busy_gap, busy_after;
    int row_idx_q[$], row_iter_q[$], col_idx_q[$], col_iter_q[$], row_last_q[$], col_first_q[$];

    ldpc_r2c_scheduler dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_max_iter    (i_max_iter),
        .i_ready       (i_ready),
        .i_parity_valid(i_parity_valid),
        .i_parity_ok   (i_parity_ok),
        .i_abort       (i_abort),
        .o_row_valid   (o_row_valid),
        .o_row_idx     (o_row_idx),
        .o_col_valid   (o_col_valid),
        .o_col_idx     (o_col_idx),
        .o_iter        (o_iter),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_converged   (o_converged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] all_outs();
        return {o_row_valid, o_row_idx, o_col_valid, o_col_idx, o_iter, o_busy, o_done, o_converged};
    endfunction

    // Drives one decode (start in cycle 0) and logs what the DUT presents each cycle.
    // conv_at: iteration whose check reports ok (beyond limit = never).
    // rmode: 0 ready always, 1 random ready, 2 three-cycle stalls at row 4 and col 2.
    task automatic run_decode(input int max_iter, input int conv_at, input int rmode,
                              input bit pv_rand, input int start_pulse_cyc);
        int  cyc;
        int  completed;
        int  stall_left;
        bit  row_stalled, col_stalled, prev_cv, rdy;
        done_cyc = -1; done_count = 0; done_conv = -1; done_iter = -1;
        overlap = 0; busy_gap = 0; busy_after = -1;
        row_idx_q.delete(); row_iter_q.delete(); col_idx_q.delete(); col_iter_q.delete();
        row_last_q.delete(); col_first_q.delete();
        completed = 0; stall_left = 0; row_stalled = 1'b0; col_stalled = 1'b0; prev_cv = 1'b0;
        i_abort = 1'b0;
        i_start = 1'b1;
        i_max_iter = 4'(max_iter);
        i_ready = 1'b1;
        i_parity_valid = 1'b1;
        i_parity_ok = 1'b0;
        tick();
        i_start = 1'b0;
        cyc = 1;
        while (cyc <= BUDGET) begin
            if (o_done) begin
                done_count++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; done_conv = int'(o_converged); done_iter = int'(o_iter);
                end
            end
            if (done_cyc < 0 && !o_done && !o_busy) busy_gap++;
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(o_busy);
            if (o_row_valid && o_col_valid) overlap++;
            if (rmode == 2 && stall_left == 0) begin
                if (!row_stalled && o_row_valid && o_row_idx == 3'd4) begin
                    row_stalled = 1'b1; stall_left = 3;
                end else if (!col_stalled && o_col_valid && o_col_idx == 3'd2) begin
                    col_stalled = 1'b1; stall_left = 3;
                end
            end
            if (rmode == 1) rdy = ($urandom_range(0, 3) != 0);
            else if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
            else rdy = 1'b1;
            i_ready = rdy;
            if (o_row_valid && rdy) begin
                row_idx_q.push_back(int'(o_row_idx));
                row_iter_q.push_back(int'(o_iter));
                if (o_row_idx == 3'(NR - 1)) row_last_q.push_back(cyc);
            end
            if (o_col_valid && !prev_cv) col_first_q.push_back(cyc);
            prev_cv = o_col_valid;
            if (o_col_valid && rdy) begin
                col_idx_q.push_back(int'(o_col_idx));
                col_iter_q.push_back(int'(o_iter));
                if (o_col_idx == 3'(NC - 1)) completed++;
            end
            i_parity_ok = (completed == conv_at + 1);
            i_parity_valid = pv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_start = (cyc == start_pulse_cyc);
            if (cyc == start_pulse_cyc) i_max_iter = 4'd9;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            tick();
            cyc++;
        end
        i_start = 1'b0;
        i_ready = 1'b0;
        i_parity_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0; i_max_iter = 4'd0; i_ready = 1'b0;
        i_parity_valid = 1'b0; i_parity_ok = 1'b0; i_abort = 1'b0;
        tick();
        total_cnt++;
        if (all_outs() !== 16'h0) $display("FAIL reset_outputs: got %h expected 0", all_outs());
        else pass_cnt++;
        tick();
        i_reset = 1'b0;
        i_ready = 1'b1; i_parity_valid = 1'b1; i_parity_ok = 1'b1; i_abort = 1'b1;
        tick(); tick();
        total_cnt++;
        if (all_outs() !== 16'h0) $display("FAIL idle_ignores_inputs: got %h expected 0", all_outs());
        else pass_cnt++;
        i_abort = 1'b0;
    endtask

    // Beat-level model: iters iterations, each presenting rows 0..NR-1 then cols 0..NC-1
    task automatic check_model(input string nm, input int iters, input int conv, input int exp_done);
        total_cnt++;
        if (done_count !== 1) $display("FAIL %s done_count: got %0d expected 1", nm, done_count);
        else pass_cnt++;
        if (exp_done >= 0) begin
            total_cnt++;
            if (done_cyc !== exp_done) $display("FAIL %s done_cycle: got %0d expected %0d", nm, done_cyc, exp_done);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_conv !== conv) $display("FAIL %s converged: got %0d expected %0d", nm, done_conv, conv);
        else pass_cnt++;
        total_cnt++;
        if (done_iter !== iters - 1) $display("FAIL %s iter: got %0d expected %0d", nm, done_iter, iters - 1);
        else pass_cnt++;
        total_cnt++;
        if (row_idx_q.size() !== NR * iters || col_idx_q.size() !== NC * iters)
            $display("FAIL %s beat_counts: got rows %0d cols %0d expected %0d %0d", nm,
                     row_idx_q.size(), col_idx_q.size(), NR * iters, NC * iters);
        else pass_cnt++;
        for (int k = 0; k < row_idx_q.size() && k < NR * iters; k++) begin
            total_cnt++;
            if (row_idx_q[k] !== k % NR || row_iter_q[k] !== k / NR)
                $display("FAIL %s row_beat%0d: got idx %0d iter %0d expected %0d %0d", nm, k,
                         row_idx_q[k], row_iter_q[k], k % NR, k / NR);
            else pass_cnt++;
        end
        for (int k = 0; k < col_idx_q.size() && k < NC * iters; k++) begin
            total_cnt++;
            if (col_idx_q[k] !== k % NC || col_iter_q[k] !== k / NC)
                $display("FAIL %s col_beat%0d: got idx %0d iter %0d expected %0d %0d", nm, k,
                         col_idx_q[k], col_iter_q[k], k % NC, k / NC);
            else pass_cnt++;
        end
        for (int k = 0; k < row_last_q.size() && k < col_first_q.size(); k++) begin
            total_cnt++;
            if (col_first_q[k] - row_last_q[k] !== PL + 1)
                $display("FAIL %s drain_gap%0d: got %0d expected %0d", nm, k,
                         col_first_q[k] - row_last_q[k], PL + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if (overlap !== 0 || busy_gap !== 0 || busy_after !== 0)
            $display("FAIL %s flags: got overlap %0d busy_gap %0d busy_after %0d expected 0 0 0", nm,
                     overlap, busy_gap, busy_after);
        else pass_cnt++;
    endtask

    task automatic test_iter_limit();
        run_decode(2, 99, 0, 1'b0, -1);
        check_model("iter_limit", 2, 0, 33);
    endtask

    task automatic test_early_conv();
        run_decode(8, 0, 0, 1'b0, -1);
        check_model("early_conv", 1, 1, 17);
    endtask

    task automatic test_backpressure();
        run_decode(3, 0, 2, 1'b0, -1);
        check_model("backpressure", 1, 1, 23);
    endtask

    task automatic test_limit_zero_start_busy();
        run_decode(0, 99, 0, 1'b0, 12);
        check_model("limit_zero", 1, 0, 17);
    endtask

    task automatic test_abort();
        int cyc;
        bit seen_done;
        i_start = 1'b1; i_max_iter = 4'd5; i_ready = 1'b1; i_parity_valid = 1'b0; i_parity_ok = 1'b0;
        tick();
        i_start = 1'b0;
        cyc = 1;
        while (cyc < 100 && !(o_col_valid && o_col_idx == 3'd3)) begin tick(); cyc++; end
        total_cnt++;
        if (cyc !== 13) $display("FAIL abort_reach_col3: got cycle %0d expected 13", cyc);
        else pass_cnt++;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        total_cnt++;
        if ({o_busy, o_col_valid, o_row_valid, o_done, o_converged} !== 5'b0)
            $display("FAIL abort_idle: got %b expected 00000",
                     {o_busy, o_col_valid, o_row_valid, o_done, o_converged});
        else pass_cnt++;
        seen_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (o_done || o_busy) seen_done = 1'b1;
            tick();
        end
        total_cnt++;
        if (seen_done !== 1'b0) $display("FAIL abort_quiet: got activity 1 expected 0");
        else pass_cnt++;
        run_decode(1, 0, 0, 1'b0, -1);
        check_model("after_abort", 1, 1, 17);
    endtask

    task automatic test_async_reset();
        int cyc;
        i_start = 1'b1; i_max_iter = 4'd4; i_ready = 1'b1; i_parity_valid = 1'b0;
        tick();
        i_start = 1'b0;
        for (cyc = 1; cyc < 8; cyc++) tick();
        total_cnt++;
        if ({o_busy, o_row_valid, o_col_valid} !== 3'b100)
            $display("FAIL areset_in_drain: got %b expected 100", {o_busy, o_row_valid, o_col_valid});
        else pass_cnt++;
        #2 i_reset = 1'b1;
        #1;
        total_cnt++;
        if (all_outs() !== 16'h0) $display("FAIL areset_immediate: got %h expected 0", all_outs());
        else pass_cnt++;
        #2 i_reset = 1'b0;
        tick();
        total_cnt++;
        if (all_outs() !== 16'h0) $display("FAIL areset_release: got %h expected 0", all_outs());
        else pass_cnt++;
        run_decode(1, 5, 0, 1'b0, -1);
        check_model("after_areset", 1, 0, 17);
    endtask

    task automatic test_random();
        int mi, ca, eff, iters, conv;
        for (int t = 0; t < 8; t++) begin
            mi = $urandom_range(0, 4);
            ca = $urandom_range(0, 5);
            eff = (mi == 0) ? 1 : mi;
            iters = (ca + 1 < eff) ? ca + 1 : eff;
            conv = (ca < eff) ? 1 : 0;
            run_decode(mi, ca, 1, 1'b1, -1);
            check_model($sformatf("random%0d", t), iters, conv, -1);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_iter_limit();
        tick();
        test_early_conv();
        tick();
        test_backpressure();
        tick();
        test_limit_zero_start_busy();
        tick();
        test_abort();
        tick();
        test_async_reset();
        tick();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
